button_debouncer: RTL and testbench

Conditions a raw, asynchronous, mechanically bouncing push-button into the clean `sButton` stimulus consumed by the on/off light switch (behavioural and structural versions alike). Synchronizes the raw input to `sClk`, filters bounce with a stability counter and a four-state FSM, and emits a one-cycle press pulse per debounced press. This block is the producer end of the `sButton` interface: the switch only ever sees glitch-free, synchronous, single-cycle presses.

---
 rtl/button_debouncer_pkg.sv | 14 +
 rtl/button_debouncer_if.sv | 24 ++
 rtl/button_debouncer_sync_2ff.sv | 27 ++
 rtl/button_debouncer.sv | 99 +++++++++
 tb/tb_button_debouncer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings
// (also used to decode state in waveforms) and the default qualification length.
package button_debouncer_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW   = 2'd0,
      CHECK_HIGH = 2'd1,
      IDLE_HIGH  = 2'd2,
      CHECK_LOW  = 2'd3
   } db_state_e;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/button_debouncer_if.sv
// Button signal bundle: raw level in, clean press/release pulses and level out.
// master = debouncer (producer), slave = consumer / stimulus side.
interface button_debouncer_if;

   logic sRawButton;
   logic sButton;
   logic sRelease;
   logic sLevel;

   modport master (
      input  sRawButton,
      output sButton,
      output sRelease,
      output sLevel
   );

   modport slave (
      output sRawButton,
      input  sButton,
      input  sRelease,
      input  sLevel
   );

endinterface

// File: rtl/button_debouncer_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs on the sClk domain.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             sClk,
   input  logic             sReset,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_sync0;
   logic [WIDTH-1:0] r_sync1;

   // first stage may go metastable; only the second stage is consumed
   always_ff @(posedge sClk or posedge sReset) begin
      if (sReset) begin
         r_sync0 <= '0;
         r_sync1 <= '0;
      end else begin
         r_sync0 <= i_async;
         r_sync1 <= r_sync0;
      end
   end

   assign o_sync = r_sync1;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button: synchronizes it, qualifies each new level for
// DEBOUNCE_CYCLES samples, and emits one-cycle press/release pulses.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic                sClk,
   input  logic                sReset,
   button_debouncer_if.master  bus
);

   localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]    CNT_ZERO = '0;
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             w_sync;
   db_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_press;
   logic             r_release;

   sync_2ff #(.WIDTH(1)) u_sync (
      .sClk    (sClk),
      .sReset  (sReset),
      .i_async (bus.sRawButton),
      .o_sync  (w_sync)
   );

   // Qualification FSM; a sample back at the current level restarts from IDLE
   always_ff @(posedge sClk or posedge sReset) begin
      if (sReset) begin
         r_state   <= IDLE_LOW;
         r_cnt     <= CNT_ZERO;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         case (r_state)
            IDLE_LOW: begin
               if (w_sync) begin
                  r_state <= CHECK_HIGH;
                  r_cnt   <= CNT_ONE;
               end else begin
                  r_cnt   <= CNT_ZERO;
               end
            end
            CHECK_HIGH: begin
               if (!w_sync) begin
                  r_state <= IDLE_LOW;
                  r_cnt   <= CNT_ZERO;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= IDLE_HIGH;
                  r_cnt   <= CNT_ZERO;
                  r_level <= 1'b1;
                  r_press <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + CNT_ONE;
               end
            end
            IDLE_HIGH: begin
               if (!w_sync) begin
                  r_state <= CHECK_LOW;
                  r_cnt   <= CNT_ONE;
               end else begin
                  r_cnt   <= CNT_ZERO;
               end
            end
            CHECK_LOW: begin
               if (w_sync) begin
                  r_state <= IDLE_HIGH;
                  r_cnt   <= CNT_ZERO;
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= IDLE_LOW;
                  r_cnt     <= CNT_ZERO;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
               end else begin
                  r_cnt     <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= IDLE_LOW;
               r_cnt   <= CNT_ZERO;
               r_level <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sButton  = r_press;
   assign bus.sRelease = r_release;
   assign bus.sLevel   = r_level;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (DEBOUNCE_CYCLES=4); outputs checked as
// {sLevel, sButton, sRelease} one time unit after each rising edge.
module tb_button_debouncer;

   logic sClk = 1'b0;
   logic sReset;
   int   n_cmp = 0;
   int   n_err = 0;
   logic r_light;
   int   toggles;

   button_debouncer_if bus ();

   button_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
      .sClk   (sClk),
      .sReset (sReset),
      .bus    (bus)
   );

   always #5 sClk = ~sClk;

   // light-switch consumer: toggles once per press pulse
   always @(posedge sClk or posedge sReset) begin
      if (sReset) begin
         r_light <= 1'b0;
         toggles <= 0;
      end else if (bus.sButton) begin
         r_light <= ~r_light;
         toggles <= toggles + 1;
      end
   end

   task automatic tick();
      @(posedge sClk);
      #1;
   endtask

   function automatic logic [2:0] outs();
      return {bus.sLevel, bus.sButton, bus.sRelease};
   endfunction

   task automatic test_reset();
      logic [2:0] exp;
      exp = 3'b000;
      sReset = 1'b1;
      bus.sRawButton = 1'b0;
      #1;
      n_cmp++;
      if (outs() !== exp) begin
         n_err++;
         $display("FAIL reset_initial: got %b expected %b", outs(), exp);
      end
      for (int i = 1; i <= 8; i++) begin
         bus.sRawButton = 1'($urandom_range(0, 1));
         tick();
         n_cmp++;
         if (outs() !== exp) begin
            n_err++;
            $display("FAIL reset_hold cycle %0d: got %b expected %b", i, outs(), exp);
         end
      end
      bus.sRawButton = 1'b0;
      tick();
      sReset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_cmp++;
         if (outs() !== exp) begin
            n_err++;
            $display("FAIL reset_release cycle %0d: got %b expected %b", i, outs(), exp);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [2:0] exp;
      bus.sRawButton = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         exp = {(i >= 6), (i == 6), 1'b0};
         n_cmp++;
         if (outs() !== exp) begin
            n_err++;
            $display("FAIL clean_press cycle %0d: got %b expected %b", i, outs(), exp);
         end
      end
   endtask

   task automatic test_release();
      logic [2:0] exp;
      bus.sRawButton = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         exp = {(i < 6), 1'b0, (i == 6)};
         n_cmp++;
         if (outs() !== exp) begin
            n_err++;
            $display("FAIL release cycle %0d: got %b expected %b", i, outs(), exp);
         end
      end
   endtask

   task automatic test_bouncy_press();
      logic [2:0] exp;
      logic [4:0] pat;
      pat = 5'b01011;
      for (int i = 1; i <= 14; i++) begin
         bus.sRawButton = (i <= 5) ? pat[i-1] : 1'b1;
         tick();
         exp = {(i >= 11), (i == 11), 1'b0};
         n_cmp++;
         if (outs() !== exp) begin
            n_err++;
            $display("FAIL bouncy_press cycle %0d: got %b expected %b", i, outs(), exp);
         end
      end
   endtask

   task automatic test_short_glitch();
      logic [2:0] exp;
      exp = 3'b000;
      for (int i = 1; i <= 10; i++) begin
         bus.sRawButton = (i <= 3) ? 1'b1 : 1'b0;
         tick();
         n_cmp++;
         if (outs() !== exp) begin
            n_err++;
            $display("FAIL short_glitch cycle %0d: got %b expected %b", i, outs(), exp);
         end
      end
   endtask

   task automatic test_min_width();
      logic [2:0] exp;
      for (int i = 1; i <= 12; i++) begin
         bus.sRawButton = (i <= 4) ? 1'b1 : 1'b0;
         tick();
         exp = {(i >= 6 && i < 10), (i == 6), (i == 10)};
         n_cmp++;
         if (outs() !== exp) begin
            n_err++;
            $display("FAIL min_width cycle %0d: got %b expected %b", i, outs(), exp);
         end
      end
   endtask

   task automatic test_reset_mid_check();
      logic [2:0] exp;
      bus.sRawButton = 1'b1;
      repeat (3) tick();
      sReset = 1'b1;
      #1;
      n_cmp++;
      if (outs() !== 3'b000) begin
         n_err++;
         $display("FAIL reset_in_check: got %b expected %b", outs(), 3'b000);
      end
      repeat (2) tick();
      sReset = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp = {(i >= 6), (i == 6), 1'b0};
         n_cmp++;
         if (outs() !== exp) begin
            n_err++;
            $display("FAIL press_after_reset cycle %0d: got %b expected %b", i, outs(), exp);
         end
      end
      bus.sRawButton = 1'b0;
      repeat (8) tick();
      bus.sRawButton = 1'b1;
      repeat (6) tick();
      n_cmp++;
      if (outs() !== 3'b110) begin
         n_err++;
         $display("FAIL pulse_before_reset: got %b expected %b", outs(), 3'b110);
      end
      sReset = 1'b1;
      #1;
      n_cmp++;
      if (outs() !== 3'b000) begin
         n_err++;
         $display("FAIL reset_in_pulse: got %b expected %b", outs(), 3'b000);
      end
      bus.sRawButton = 1'b0;
      tick();
      sReset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         n_cmp++;
         if (outs() !== 3'b000) begin
            n_err++;
            $display("FAIL dropped_pulse cycle %0d: got %b expected %b", i, outs(), 3'b000);
         end
      end
   endtask

   task automatic test_switch();
      for (int p = 0; p < 3; p++) begin
         bus.sRawButton = 1'b1;
         repeat (8) tick();
         bus.sRawButton = 1'b0;
         repeat (8) tick();
      end
      n_cmp++;
      if (toggles !== 3) begin
         n_err++;
         $display("FAIL switch_toggles: got %0d expected %0d", toggles, 3);
      end
      n_cmp++;
      if (r_light !== 1'b1) begin
         n_err++;
         $display("FAIL switch_light: got %b expected %b", r_light, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_release();
      test_bouncy_press();
      bus.sRawButton = 1'b0;
      repeat (8) tick();
      test_short_glitch();
      test_min_width();
      test_reset_mid_check();
      test_switch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
